// File: rtl/sd_spi_responder.sv
// SPI-mode SD card responder: decodes 48-bit command frames on an oversampled
// mode-0 link and answers with R1/R3/R7, tracking the idle->ready init state.
module sd_spi_responder #(
  parameter int          N_CR        = 1,
  parameter logic [31:0] OCR         = 32'hC0FF8000,
  parameter int          ACMD41_BUSY = 2,
  parameter bit          CRC_CHECK   = 1'b1
) (
  input  logic        responder_clk_i,
  input  logic        responder_rst_i,
  input  logic        spi_sck_i,
  input  logic        spi_cs_n_i,
  input  logic        spi_mosi_i,
  output logic        spi_miso_o,
  output logic        cmd_valid_o,
  output logic [5:0]  cmd_index_o,
  output logic [31:0] cmd_arg_o,
  output logic        crc_err_o,
  output logic        card_idle_o
);

  localparam logic [2:0] ST_HUNT  = 3'd0;
  localparam logic [2:0] ST_RECV  = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_NCR   = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  logic [2:0]  state;
  logic [1:0]  sck_sync, cs_sync, mosi_sync;
  logic        sck_prev;
  logic        cs_act, sck_rise, sck_fall, byte_done;
  logic [2:0]  bit_cnt;
  logic [2:0]  byte_cnt;
  logic [7:0]  rx_sr, rx_byte;
  logic [5:0]  idx_r;
  logic [31:0] arg_r;
  logic [6:0]  crc_r;
  logic [39:0] tx_sr;
  logic [5:0]  tx_cnt;
  logic [7:0]  acnt;
  logic        app_flag;

  logic [7:0]  r1;
  logic [39:0] resp_next;
  logic [5:0]  resp_bits;
  logic        idle_n, app_n;
  logic [7:0]  acnt_n;

  function automatic logic [6:0] crc7_byte(input logic [6:0] c, input logic [7:0] d);
    logic [6:0] r;
    logic       fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[6] ^ d[i];
      r  = {r[5:0], 1'b0};
      if (fb) r = r ^ 7'h09;
    end
    return r;
  endfunction

  // Edges seen while CS_n is high (including the cycle CS_n rises) are dropped.
  assign cs_act    = ~cs_sync[1];
  assign sck_rise  = cs_act & sck_sync[1] & ~sck_prev;
  assign sck_fall  = cs_act & ~sck_sync[1] & sck_prev;
  assign byte_done = sck_rise && (bit_cnt == 3'd7);
  assign rx_byte   = {rx_sr[6:0], mosi_sync[1]};

  // Response and card-state update for the frame latched in the output registers.
  always_comb begin
    r1        = {7'b0, card_idle_o};
    resp_bits = 6'd8;
    idle_n    = card_idle_o;
    acnt_n    = acnt;
    app_n     = 1'b0;
    if (crc_err_o) begin
      r1    = {4'b0000, 1'b1, 2'b00, card_idle_o};
      app_n = app_flag;
    end else begin
      case (cmd_index_o)
        6'd0: begin
          r1     = 8'h01;
          idle_n = 1'b1;
          acnt_n = 8'd0;
        end
        6'd8:  resp_bits = 6'd40;
        6'd55: app_n = 1'b1;
        6'd41: begin
          if (!app_flag) begin
            r1 = {5'b0, 1'b1, 1'b0, card_idle_o};
          end else if (acnt < 8'(ACMD41_BUSY)) begin
            r1     = 8'h01;
            acnt_n = acnt + 8'd1;
          end else begin
            r1     = 8'h00;
            idle_n = 1'b0;
          end
        end
        6'd58: resp_bits = 6'd40;
        default: r1 = {5'b0, 1'b1, 1'b0, card_idle_o};
      endcase
    end
    if (!crc_err_o && cmd_index_o == 6'd8)
      resp_next = {r1, 8'h00, 8'h00, 4'h0, cmd_arg_o[11:8], cmd_arg_o[7:0]};
    else if (!crc_err_o && cmd_index_o == 6'd58)
      resp_next = {r1, OCR};
    else
      resp_next = {r1, 32'h0};
  end

  always_ff @(posedge responder_clk_i) begin
    if (responder_rst_i) begin
      state       <= ST_HUNT;
      sck_sync    <= 2'b00;
      cs_sync     <= 2'b11;
      mosi_sync   <= 2'b11;
      sck_prev    <= 1'b0;
      bit_cnt     <= 3'd0;
      byte_cnt    <= 3'd0;
      rx_sr       <= 8'h00;
      idx_r       <= 6'd0;
      arg_r       <= 32'h0;
      crc_r       <= 7'd0;
      tx_sr       <= 40'h0;
      tx_cnt      <= 6'd0;
      acnt        <= 8'd0;
      app_flag    <= 1'b0;
      spi_miso_o  <= 1'b1;
      cmd_valid_o <= 1'b0;
      cmd_index_o <= 6'd0;
      cmd_arg_o   <= 32'h0;
      crc_err_o   <= 1'b0;
      card_idle_o <= 1'b1;
    end else begin
      sck_sync    <= {sck_sync[0], spi_sck_i};
      cs_sync     <= {cs_sync[0], spi_cs_n_i};
      mosi_sync   <= {mosi_sync[0], spi_mosi_i};
      sck_prev    <= sck_sync[1];
      cmd_valid_o <= 1'b0;
      if (!cs_act) begin
        state      <= ST_HUNT;
        bit_cnt    <= 3'd0;
        byte_cnt   <= 3'd0;
        spi_miso_o <= 1'b1;
      end else begin
        if (sck_rise) begin
          rx_sr   <= rx_byte;
          bit_cnt <= bit_cnt + 3'd1;
        end
        case (state)
          ST_HUNT: begin
            spi_miso_o <= 1'b1;
            if (byte_done && rx_byte[7:6] == 2'b01) begin
              idx_r    <= rx_byte[5:0];
              crc_r    <= crc7_byte(7'd0, rx_byte);
              byte_cnt <= 3'd1;
              state    <= ST_RECV;
            end
          end
          ST_RECV: begin
            if (byte_done) begin
              if (byte_cnt == 3'd5) begin
                // Outputs change together with the pulse so CHECK sees this frame.
                cmd_valid_o <= 1'b1;
                cmd_index_o <= idx_r;
                cmd_arg_o   <= arg_r;
                crc_err_o   <= CRC_CHECK && (rx_byte != {crc_r, 1'b1});
                state       <= ST_CHECK;
              end else begin
                arg_r    <= {arg_r[23:0], rx_byte};
                crc_r    <= crc7_byte(crc_r, rx_byte);
                byte_cnt <= byte_cnt + 3'd1;
              end
            end
          end
          ST_CHECK: begin
            tx_sr       <= resp_next;
            tx_cnt      <= resp_bits;
            card_idle_o <= idle_n;
            acnt        <= acnt_n;
            app_flag    <= app_n;
            byte_cnt    <= 3'd0;
            state       <= ST_NCR;
          end
          ST_NCR: begin
            if (byte_done) begin
              if (byte_cnt == 3'(N_CR - 1)) state <= ST_RESP;
              else byte_cnt <= byte_cnt + 3'd1;
            end
          end
          ST_RESP: begin
            if (sck_fall) begin
              if (tx_cnt == 6'd0) begin
                spi_miso_o <= 1'b1;
                state      <= ST_HUNT;
              end else begin
                spi_miso_o <= tx_sr[39];
                tx_sr      <= {tx_sr[38:0], 1'b0};
                tx_cnt     <= tx_cnt - 6'd1;
              end
            end
          end
          default: state <= ST_HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed bench for sd_spi_responder: a table of command frames with expected
// responses and card state, plus a hand-written aborted-frame sequence.
module tb_sd_spi_responder;
  localparam int HALF = 80;
  localparam int NCR  = 1;

  logic        clk = 1'b0;
  logic        rst, sck, cs_n, mosi;
  logic        miso, cmd_valid, crc_err, card_idle;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  sd_spi_responder dut (
    .responder_clk_i(clk),
    .responder_rst_i(rst),
    .spi_sck_i(sck),
    .spi_cs_n_i(cs_n),
    .spi_mosi_i(mosi),
    .spi_miso_o(miso),
    .cmd_valid_o(cmd_valid),
    .cmd_index_o(cmd_index),
    .cmd_arg_o(cmd_arg),
    .crc_err_o(crc_err),
    .card_idle_o(card_idle)
  );

  always @(negedge clk) if (cmd_valid) pulses++;

  typedef struct {
    logic [47:0] cmd;
    int          len;
    logic [39:0] resp;
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        cerr;
    logic        idle;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int b = 7; b >= 0; b--) begin
      mosi = tx[b];
      #(HALF - 1);
      rx[b] = miso;
      #1;
      sck = 1'b1;
      #HALF;
      sck = 1'b0;
    end
  endtask

  task automatic frame(input logic [47:0] cmd, input int nrd, output logic [63:0] rd);
    logic [7:0] b;
    rd = '0;
    cs_n = 1'b0;
    #HALF;
    for (int k = 0; k < 6; k++) xfer_byte(cmd[47 - 8*k -: 8], b);
    for (int k = 0; k < nrd; k++) begin
      xfer_byte(8'hFF, b);
      rd = {rd[55:0], b};
    end
    mosi = 1'b1;
    #HALF;
    cs_n = 1'b1;
    #(4*HALF);
  endtask

  initial begin
    logic [63:0] rd;
    logic [7:0]  b;
    int          n, p0;

    vt[0]  = '{48'h400000000095, 1, 40'h01_00000000, 6'd0,  32'h0,        1'b0, 1'b1};
    vt[1]  = '{48'h48000001AA87, 5, 40'h01_000001AA, 6'd8,  32'h000001AA, 1'b0, 1'b1};
    vt[2]  = '{48'h770000000065, 1, 40'h01_00000000, 6'd55, 32'h0,        1'b0, 1'b1};
    vt[3]  = '{48'h694000000077, 1, 40'h01_00000000, 6'd41, 32'h40000000, 1'b0, 1'b1};
    vt[4]  = '{48'h770000000065, 1, 40'h01_00000000, 6'd55, 32'h0,        1'b0, 1'b1};
    vt[5]  = '{48'h694000000077, 1, 40'h01_00000000, 6'd41, 32'h40000000, 1'b0, 1'b1};
    vt[6]  = '{48'h770000000065, 1, 40'h01_00000000, 6'd55, 32'h0,        1'b0, 1'b1};
    vt[7]  = '{48'h694000000077, 1, 40'h00_00000000, 6'd41, 32'h40000000, 1'b0, 1'b0};
    vt[8]  = '{48'h7A00000000FD, 5, 40'h00_C0FF8000, 6'd58, 32'h0,        1'b0, 1'b0};
    vt[9]  = '{48'h400000000094, 1, 40'h08_00000000, 6'd0,  32'h0,        1'b1, 1'b0};
    vt[10] = '{48'h400000000095, 1, 40'h01_00000000, 6'd0,  32'h0,        1'b0, 1'b1};
    vt[11] = '{48'h510000000055, 1, 40'h05_00000000, 6'd17, 32'h0,        1'b0, 1'b1};
    vt[12] = '{48'h694000000077, 1, 40'h05_00000000, 6'd41, 32'h40000000, 1'b0, 1'b1};

    rst = 1'b1; sck = 1'b0; cs_n = 1'b1; mosi = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_miso", 32'(miso), 32'h1);
    chk("reset_valid", 32'(cmd_valid), 32'h0);
    chk("reset_index", 32'(cmd_index), 32'h0);
    chk("reset_arg", cmd_arg, 32'h0);
    chk("reset_crc_err", 32'(crc_err), 32'h0);
    chk("reset_idle", 32'(card_idle), 32'h1);

    for (int v = 0; v < 13; v++) begin
      if (v == 10) begin
        // CMD8 cut off after three bytes: no pulse, MISO released, state kept.
        p0 = pulses;
        cs_n = 1'b0;
        #HALF;
        xfer_byte(8'h48, b);
        xfer_byte(8'h00, b);
        xfer_byte(8'h00, b);
        #HALF;
        cs_n = 1'b1;
        #(4*HALF);
        chk("abort_no_pulse", 32'(pulses), 32'(p0));
        chk("abort_miso", 32'(miso), 32'h1);
        chk("abort_idle_kept", 32'(card_idle), 32'h0);
      end
      p0 = pulses;
      n  = NCR + vt[v].len;
      frame(vt[v].cmd, n, rd);
      chk($sformatf("v%0d_pulse", v), 32'(pulses), 32'(p0 + 1));
      for (int k = 0; k < NCR; k++)
        chk($sformatf("v%0d_filler%0d", v, k), 32'(rd[8*(n-1-k) +: 8]), 32'hFF);
      for (int k = 0; k < vt[v].len; k++)
        chk($sformatf("v%0d_resp%0d", v, k), 32'(rd[8*(n-1-NCR-k) +: 8]),
            32'(vt[v].resp[39 - 8*k -: 8]));
      chk($sformatf("v%0d_index", v), 32'(cmd_index), 32'(vt[v].idx));
      chk($sformatf("v%0d_arg", v), cmd_arg, vt[v].arg);
      chk($sformatf("v%0d_crc_err", v), 32'(crc_err), 32'(vt[v].cerr));
      chk($sformatf("v%0d_idle", v), 32'(card_idle), 32'(vt[v].idle));
      chk($sformatf("v%0d_miso_idle", v), 32'(miso), 32'h1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end
endmodule
